sdram_rw_arb: RTL and testbench
===============================

SDRAM_RW_ARB -- requirements
Module: sdram_rw_arb

Interface
REQ-001 SHALL have parameter BL, default 2, SDRAM burst length in 16-bit words (1..255).
REQ-002 SHALL have parameter REF_PERIOD, default 1040, cycles between auto-refresh requests (7.8 us at 133 MHz).
REQ-003 SHALL have the following ports:
- sdram_clk  in  1  sole clock, 133 MHz.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  writer has a burst pending.
- wr_addr  in  22  writer burst start address.
- wr_data  in  16  writer data word.
- wr_grant  out  1  write burst owns the controller.
- wr_data_ack  out  1  pulse; current wr_data consumed.
- rd_req  in  1  reader has a burst pending.
- rd_addr  in  22  reader burst start address.
- rd_grant  out  1  read burst owns the controller.
- rd_data  out  16  read word to the reader.
- rd_data_valid  out  1  rd_data qualifier.
- ctl_valid  out  1  command valid to the SDRAM controller.
- ctl_op  out  2  command: 01 write, 10 read, 11 refresh.
- ctl_addr  out  22  command address.
- ctl_ready  in  1  controller accepts command.
- ctl_wdata  out  16  write data to the controller.
- ctl_wack  in  1  controller consumed ctl_wdata.
- ctl_rdata  in  16  controller read data.
- ctl_rvalid  in  1  ctl_rdata qualifier.
- ctl_done  in  1  pulse; burst or refresh complete.
- ref_overrun  out  1  sticky; a refresh period elapsed with refresh still pending.
- stat_wr_cnt  out  16  completed write bursts.
- stat_rd_cnt  out  16  completed read bursts.

Function
REQ-004 SHALL implement states IDLE, REF, WR, RD.
REQ-005 Refresh counter SHALL count 0..REF_PERIOD-1 and wrap; at REF_PERIOD-1 it SHALL set ref_pending.
REQ-006 In IDLE, arbitration priority SHALL be ref_pending first, then wr_req/rd_req round-robin.
- Round-robin: when both request, grant the one not served last; last_served resets to "read", so write wins the first tie.
- A lone requester SHALL be granted regardless of last_served.
REQ-007 On grant (IDLE exit):
- Latch the chosen address into ctl_addr and the op into ctl_op; ctl_addr is 0 for refresh.
- Assert ctl_valid on the next cycle.
- Assert wr_grant or rd_grant from that cycle until the cycle after ctl_done.
REQ-008 ctl_valid, ctl_op and ctl_addr SHALL stay stable until sampled with ctl_ready high; ctl_valid SHALL deassert on the following cycle.
REQ-009 In WR: ctl_wdata SHALL equal wr_data combinationally, and wr_data_ack SHALL equal ctl_wack; outside WR, wr_data_ack SHALL be 0.
REQ-010 In RD: rd_data SHALL be ctl_rdata registered one cycle, and rd_data_valid SHALL be ctl_rvalid registered one cycle; ctl_rvalid outside RD SHALL be ignored.
REQ-011 ctl_done in REF/WR/RD SHALL return the machine to IDLE next cycle, and SHALL update last_served for WR/RD.
- ref_pending SHALL clear when the refresh command is accepted (ctl_valid & ctl_ready in REF).
REQ-012 If ref_pending is already set when the counter wraps again, ref_overrun SHALL set and hold until reset.
- The counter SHALL keep running during any burst.
REQ-013 A refresh becoming due mid-burst SHALL NOT preempt the burst; REF SHALL be entered at the next IDLE.
REQ-014 ctl_done in IDLE SHALL be ignored.
REQ-015 Requests deasserting after grant SHALL NOT abort the burst.
REQ-016 Minimum turnaround SHALL be one IDLE cycle between consecutive commands.

Reset
REQ-017 While rst is high at a sdram_clk edge, the block SHALL be in this state next cycle:
- state IDLE; refresh counter 0; ref_pending 0; last_served read.
- ctl_valid, ctl_op, ctl_addr 0; all grants 0; rd_data, rd_data_valid 0.
- ref_overrun 0; stat counters 0.
REQ-018 Reset asserted mid-burst SHALL abandon the burst immediately with no completion signalling.

Configuration
REQ-019 With SDRAM_ARB_STAT_EN defined:
- stat_wr_cnt and stat_rd_cnt SHALL increment on ctl_done in WR and RD respectively.
- Both SHALL saturate at 16'hFFFF.
REQ-020 Without SDRAM_ARB_STAT_EN, stat_wr_cnt and stat_rd_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-021 Reset then wr_req=1, wr_addr=22'h100, ctl_ready=1, two ctl_wack pulses, then ctl_done -> ctl_op=01, ctl_addr=22'h100, two wr_data_ack pulses, wr_grant drops the cycle after ctl_done.
REQ-022 wr_req and rd_req both held high across four bursts -> grant order W,R,W,R.
REQ-023 REF_PERIOD=16 with rd_req idle -> ctl_op=11 issued every 16 cycles, and ref_pending cleared on accept.
REQ-024 Refresh due during a 40-cycle read burst with REF_PERIOD=16 -> refresh issued after ctl_done, and ref_overrun=1 after the second wrap.
REQ-025 ctl_ready held 0 for 5 cycles -> ctl_valid, ctl_op, ctl_addr stable all 5 cycles.
REQ-026 rst pulsed mid-write burst -> all outputs at reset values next cycle; with SDRAM_ARB_STAT_EN, 3 completed writes give stat_wr_cnt=3.

Source files
------------

// File: rtl/sdram_rw_arb_if.sv
// rtl/sdram_rw_arb_if.sv - writer, reader and SDRAM-controller signals of sdram_rw_arb
// master is the arbiter side; slave is the requester/controller side.
interface sdram_rw_arb_if;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_grant;
  logic        wr_data_ack;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_grant;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        ctl_valid;
  logic [1:0]  ctl_op;
  logic [21:0] ctl_addr;
  logic        ctl_ready;
  logic [15:0] ctl_wdata;
  logic        ctl_wack;
  logic [15:0] ctl_rdata;
  logic        ctl_rvalid;
  logic        ctl_done;
  logic        ref_overrun;
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;

  modport master (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
           ctl_ready, ctl_wack, ctl_rdata, ctl_rvalid, ctl_done,
    output wr_grant, wr_data_ack, rd_grant, rd_data, rd_data_valid,
           ctl_valid, ctl_op, ctl_addr, ctl_wdata,
           ref_overrun, stat_wr_cnt, stat_rd_cnt
  );

  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
           ctl_ready, ctl_wack, ctl_rdata, ctl_rvalid, ctl_done,
    input  wr_grant, wr_data_ack, rd_grant, rd_data, rd_data_valid,
           ctl_valid, ctl_op, ctl_addr, ctl_wdata,
           ref_overrun, stat_wr_cnt, stat_rd_cnt
  );
endinterface

// File: rtl/sdram_rw_arb.sv
// rtl/sdram_rw_arb.sv - write/read/refresh arbiter in front of an SDRAM controller
// Optional saturating burst counters: define SDRAM_ARB_STAT_EN.
module sdram_rw_arb #(
  parameter int BL         = 2,
  parameter int REF_PERIOD = 1040
) (
  input  logic           sdram_clk,
  input  logic           rst,
  sdram_rw_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, REF, WR, RD} state_t;

  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_REF = 2'b11;
  localparam int         CW     = $clog2(REF_PERIOD);

  if (BL < 1 || BL > 255 || REF_PERIOD < 2) begin : g_param_check
    $error("sdram_rw_arb: parameter out of range");
  end

  state_t      state, state_next;
  logic [CW-1:0] ref_cnt;
  logic        ref_pending, ref_wrap, ref_accept, ref_overrun_q;
  logic        last_rd;
  logic        ctl_valid_q;
  logic [1:0]  ctl_op_q, op_next;
  logic [21:0] ctl_addr_q, addr_next;
  logic        grant_load, burst_done;
  logic [15:0] rd_data_q;
  logic        rd_data_valid_q;

  assign ref_wrap   = (ref_cnt == CW'(REF_PERIOD - 1));
  assign ref_accept = (state == REF) && ctl_valid_q && bus.ctl_ready;
  assign burst_done = (state != IDLE) && bus.ctl_done;

  // The refresh timer free-runs through bursts; a wrap beats a same-cycle accept.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      ref_cnt       <= '0;
      ref_pending   <= 1'b0;
      ref_overrun_q <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap)
        ref_pending <= 1'b1;
      else if (ref_accept)
        ref_pending <= 1'b0;
      if (ref_wrap && ref_pending)
        ref_overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    op_next    = ctl_op_q;
    addr_next  = ctl_addr_q;
    case (state)
      IDLE: begin
        if (ref_pending) begin
          state_next = REF;
          grant_load = 1'b1;
          op_next    = OP_REF;
          addr_next  = '0;
        end else if (bus.wr_req && (!bus.rd_req || last_rd)) begin
          state_next = WR;
          grant_load = 1'b1;
          op_next    = OP_WR;
          addr_next  = bus.wr_addr;
        end else if (bus.rd_req) begin
          state_next = RD;
          grant_load = 1'b1;
          op_next    = OP_RD;
          addr_next  = bus.rd_addr;
        end
      end
      REF, WR, RD: begin
        if (bus.ctl_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      ctl_valid_q <= 1'b0;
      ctl_op_q    <= '0;
      ctl_addr_q  <= '0;
      last_rd     <= 1'b1;
    end else begin
      if (grant_load) begin
        ctl_valid_q <= 1'b1;
        ctl_op_q    <= op_next;
        ctl_addr_q  <= addr_next;
      end else if (burst_done || (ctl_valid_q && bus.ctl_ready)) begin
        ctl_valid_q <= 1'b0;
      end
      if (burst_done && state == WR)
        last_rd <= 1'b0;
      else if (burst_done && state == RD)
        last_rd <= 1'b1;
    end
  end

  // Read data is retimed; stray ctl_rvalid outside a read burst never reaches the reader.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      rd_data_valid_q <= (state == RD) && bus.ctl_rvalid;
      if ((state == RD) && bus.ctl_rvalid)
        rd_data_q <= bus.ctl_rdata;
    end
  end

  assign bus.wr_grant      = (state == WR);
  assign bus.rd_grant      = (state == RD);
  assign bus.wr_data_ack   = (state == WR) && bus.ctl_wack;
  assign bus.ctl_wdata     = (state == WR) ? bus.wr_data : '0;
  assign bus.ctl_valid     = ctl_valid_q;
  assign bus.ctl_op        = ctl_op_q;
  assign bus.ctl_addr      = ctl_addr_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.ref_overrun   = ref_overrun_q;

`ifdef SDRAM_ARB_STAT_EN
  logic [15:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (burst_done && state == WR && stat_wr_q != 16'hFFFF)
        stat_wr_q <= stat_wr_q + 16'd1;
      if (burst_done && state == RD && stat_rd_q != 16'hFFFF)
        stat_rd_q <= stat_rd_q + 16'd1;
    end
  end

  assign bus.stat_wr_cnt = stat_wr_q;
  assign bus.stat_rd_cnt = stat_rd_q;
`else
  assign bus.stat_wr_cnt = '0;
  assign bus.stat_rd_cnt = '0;
`endif
endmodule

// File: tb/tb_sdram_rw_arb.sv
// tb/tb_sdram_rw_arb.sv - randomized bench for sdram_rw_arb against a transaction-level model
module tb_sdram_rw_arb;
  localparam int P  = 16;
  localparam int BL = 2;
`ifdef SDRAM_ARB_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic sdram_clk = 1'b0;
  logic rst;
  always #5 sdram_clk = ~sdram_clk;

  sdram_rw_arb_if bus();
  sdram_rw_arb #(.BL(BL), .REF_PERIOD(P)) dut (.sdram_clk(sdram_clk), .rst(rst), .bus(bus));

  int n_checks = 0, n_fail = 0;
  int ecyc = 0;

  // Model of what the arbiter owes the outside world, kept per transaction.
  bit          m_busy, m_valid, pend, ovr, last_rd, m_rdv;
  logic [1:0]  m_op;
  logic [21:0] m_addr;
  logic [15:0] m_rdd;
  int          wcnt, rcnt;

  // Stimulus knobs and controller-responder bookkeeping.
  bit          rst_q = 1'b1, rand_req = 1'b0, wr_q = 1'b0, rd_q = 1'b0;
  bit          fix_addr = 1'b0, ready_always = 1'b0;
  logic [21:0] wa_fix = '0, ra_fix = '0;
  int          beats, wait_cnt, block_cnt = 0, next_block = 0, done_wait_ovr = -1;

  bit          prev_v = 1'b0;
  logic [1:0]  obs_op[$];
  logic [21:0] obs_addr[$];
  int          obs_cyc[$];
  int          ack_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, ecyc);
    end
  endtask

  function automatic logic [31:0] sat16(input int v);
    return STAT_ON ? ((v > 65535) ? 32'd65535 : 32'(v)) : 32'd0;
  endfunction

  function automatic logic [31:0] obs_op_at(input int i);
    return (i < obs_op.size()) ? 32'(obs_op[i]) : 32'hDEAD;
  endfunction

  function automatic int count_op(input logic [1:0] op);
    int n = 0;
    foreach (obs_op[i]) if (obs_op[i] == op) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_valid = 0; pend = 0; ovr = 0; last_rd = 1; m_rdv = 0;
    m_op = '0; m_addr = '0; m_rdd = '0; wcnt = 0; rcnt = 0; ecyc = 0;
  endtask

  task automatic step();
    bit acc, wrap;
    // drive inputs for the coming edge
    rst = rst_q;
    bus.wr_req  = rand_req ? ($urandom % 3 == 0) : wr_q;
    bus.rd_req  = rand_req ? ($urandom % 3 == 0) : rd_q;
    bus.wr_addr = fix_addr ? wa_fix : 22'($urandom);
    bus.rd_addr = fix_addr ? ra_fix : 22'($urandom);
    bus.wr_data = 16'($urandom);
    bus.ctl_rdata = 16'($urandom);
    bus.ctl_ready = ready_always || (block_cnt == 0 && $urandom % 3 != 0);
    if (block_cnt > 0) block_cnt--;
    bus.ctl_wack = 0; bus.ctl_rvalid = 0; bus.ctl_done = 0;
    if (m_busy && !m_valid) begin
      if (m_op != 2'b11 && beats < BL) begin
        if ($urandom % 2 == 1) begin
          if (m_op == 2'b01) bus.ctl_wack = 1; else bus.ctl_rvalid = 1;
          beats++;
        end
      end else if (wait_cnt == 0) bus.ctl_done = 1;
      else wait_cnt--;
    end
    if (!(m_busy && m_op == 2'b01)) bus.ctl_wack = ($urandom % 4 == 0);
    if (!(m_busy && m_op == 2'b10)) bus.ctl_rvalid = ($urandom % 4 == 0);
    if (!m_busy) bus.ctl_done = ($urandom % 8 == 0);
    #1;
    check_val("wr_data_ack", bus.wr_data_ack, m_busy && m_op == 2'b01 && bus.ctl_wack);
    if (m_busy && m_op == 2'b01) check_val("ctl_wdata", bus.ctl_wdata, bus.wr_data);
    if (bus.wr_data_ack) ack_seen++;

    @(posedge sdram_clk);
    if (rst) begin
      model_reset();
    end else begin
      ecyc++;
      wrap  = (ecyc % P == 0);
      acc   = m_busy && m_valid && bus.ctl_ready;
      m_rdv = m_busy && m_op == 2'b10 && bus.ctl_rvalid;
      if (m_rdv) m_rdd = bus.ctl_rdata;
      if (wrap && pend) ovr = 1;
      if (m_busy) begin
        if (acc && m_op == 2'b11) pend = 0;
        if (bus.ctl_done) begin
          m_busy = 0; m_valid = 0;
          if (m_op == 2'b01) begin last_rd = 0; wcnt++; end
          else if (m_op == 2'b10) begin last_rd = 1; rcnt++; end
        end else if (acc) m_valid = 0;
      end else if (pend || bus.wr_req || bus.rd_req) begin
        m_busy = 1; m_valid = 1;
        if (pend) begin m_op = 2'b11; m_addr = '0; end
        else if (bus.wr_req && (!bus.rd_req || last_rd)) begin m_op = 2'b01; m_addr = bus.wr_addr; end
        else begin m_op = 2'b10; m_addr = bus.rd_addr; end
        beats = 0;
        wait_cnt = (done_wait_ovr >= 0) ? done_wait_ovr : $urandom_range(0, 3);
        block_cnt = next_block; next_block = 0;
      end
      if (wrap) pend = 1;
    end

    @(negedge sdram_clk);
    check_val("ctl_valid", bus.ctl_valid, m_valid);
    check_val("ctl_op", bus.ctl_op, m_op);
    check_val("ctl_addr", bus.ctl_addr, m_addr);
    check_val("wr_grant", bus.wr_grant, m_busy && m_op == 2'b01);
    check_val("rd_grant", bus.rd_grant, m_busy && m_op == 2'b10);
    check_val("rd_data_valid", bus.rd_data_valid, m_rdv);
    check_val("rd_data", bus.rd_data, m_rdd);
    check_val("ref_overrun", bus.ref_overrun, ovr);
    check_val("stat_wr_cnt", bus.stat_wr_cnt, sat16(wcnt));
    check_val("stat_rd_cnt", bus.stat_rd_cnt, sat16(rcnt));
    if (bus.ctl_valid && !prev_v) begin
      obs_op.push_back(bus.ctl_op); obs_addr.push_back(bus.ctl_addr); obs_cyc.push_back(ecyc);
    end
    prev_v = bus.ctl_valid;
  endtask

  task automatic do_reset();
    rst_q = 1; wr_q = 0; rd_q = 0; rand_req = 0;
    step(); step();
    rst_q = 0;
    obs_op.delete(); obs_addr.delete(); obs_cyc.delete(); ack_seen = 0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (m_busy && n < limit) begin step(); n++; end
    check_val("drain_bound", m_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, start;
    logic [1:0] wr_rd[$];

    // reset state
    do_reset();
    check_val("rst_valid", bus.ctl_valid, 0);
    check_val("rst_op", bus.ctl_op, 0);
    check_val("rst_addr", bus.ctl_addr, 0);
    check_val("rst_grants", {bus.wr_grant, bus.rd_grant}, 0);
    check_val("rst_rd", {bus.rd_data_valid, bus.rd_data}, 0);
    check_val("rst_ovr", bus.ref_overrun, 0);

    // single write burst, request dropped right after grant
    fix_addr = 1; wa_fix = 22'h100;
    wr_q = 1; step(); wr_q = 0;
    drain(60);
    check_val("w_op", obs_op_at(0), 1);
    check_val("w_addr", (obs_addr.size() > 0) ? 32'(obs_addr[0]) : 32'hDEAD, 32'h100);
    check_val("w_acks", ack_seen, BL);
    check_val("w_grant_drop", bus.wr_grant, 0);

    // round-robin with both requesters held
    do_reset();
    wr_q = 1; rd_q = 1; n = 0;
    while ((count_op(2'b01) + count_op(2'b10)) < 4 && n < 400) begin step(); n++; end
    wr_q = 0; rd_q = 0;
    drain(60);
    foreach (obs_op[i]) if (obs_op[i] != 2'b11) wr_rd.push_back(obs_op[i]);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("rr_order%0d", i), (i < wr_rd.size()) ? 32'(wr_rd[i]) : 32'hDEAD,
                (i % 2 == 0) ? 32'd1 : 32'd2);

    // refresh cadence with no traffic
    do_reset();
    ready_always = 1;
    repeat (70) step();
    ready_always = 0;
    check_val("ref_count", count_op(2'b11), 4);
    check_val("ref_first", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, P + 1);
    for (int i = 1; i < obs_cyc.size(); i++)
      check_val("ref_spacing", obs_cyc[i] - obs_cyc[i-1], P);

    // long read straddling two refresh wraps
    do_reset();
    fix_addr = 0;
    rd_q = 1; done_wait_ovr = 36; step(); rd_q = 0;
    drain(100);
    done_wait_ovr = -1;
    n = 0;
    while (obs_op.size() < 2 && n < 20) begin step(); n++; end
    check_val("long_rd_op", obs_op_at(0), 2);
    check_val("ref_after_rd", obs_op_at(1), 3);
    check_val("overrun_set", bus.ref_overrun, 1);
    drain(60);

    // command held while ctl_ready is low
    do_reset();
    fix_addr = 1; wa_fix = 22'($urandom);
    next_block = 5; wr_q = 1;
    for (int i = 0; i < 5; i++) begin
      step(); wr_q = 0;
      check_val("hold_valid", bus.ctl_valid, 1);
      check_val("hold_op", bus.ctl_op, 1);
      check_val("hold_addr", bus.ctl_addr, 32'(wa_fix));
    end
    drain(60);
    fix_addr = 0;

    // reset in the middle of a write, then three full writes
    do_reset();
    wr_q = 1; step(); wr_q = 0; step(); step();
    rst_q = 1; step(); rst_q = 0;
    check_val("mid_rst_valid", bus.ctl_valid, 0);
    check_val("mid_rst_op", bus.ctl_op, 0);
    check_val("mid_rst_addr", bus.ctl_addr, 0);
    check_val("mid_rst_grant", {bus.wr_grant, bus.rd_grant}, 0);
    check_val("mid_rst_rd", {bus.rd_data_valid, bus.rd_data}, 0);
    check_val("mid_rst_stat", bus.stat_wr_cnt, 0);
    obs_op.delete(); obs_addr.delete(); obs_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      start = count_op(2'b01); n = 0; wr_q = 1;
      while (count_op(2'b01) == start && n < 50) begin step(); n++; end
      wr_q = 0;
      drain(60);
    end
    check_val("three_writes", bus.stat_wr_cnt, STAT_ON ? 32'd3 : 32'd0);

    // random traffic
    rand_req = 1;
    repeat (1500) step();
    rand_req = 0;
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
